// File: rtl/usbfs_endp_in_buf.sv
// Buffered USB full-speed IN endpoint: packs an upstream byte stream into one packet
// buffer and holds it until the host ACKs it. Also manages the DATA0/1 toggle, ZLPs and halt.
module usbfs_endp_in_buf #(
  parameter int MAX_PKT      = 8,
  parameter int FLUSH_CYCLES = 0,
  parameter int ZLP_EN       = 1,
  localparam int IDX_W       = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1,
  localparam int NBYTES_W    = $clog2(MAX_PKT + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic                o_ready,
  input  logic                i_valid,
  input  logic [7:0]          i_data,
  input  logic                i_last,
  input  logic                i_etReady,
  output logic                o_etValid,
  output logic                o_etStall,
  output logic                o_etDataPid,
  output logic [NBYTES_W-1:0] o_etNBytes,
  input  logic [IDX_W-1:0]    i_etRdIdx,
  output logic [7:0]          o_etRdByte,
  input  logic                i_toggleClr,
  input  logic                i_haltSet,
  input  logic                i_haltClr
);

  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 2);

  typedef enum logic [1:0] {S_FILL, S_SEALED, S_ZLP} state_e;

  state_e              state_q, state_d;
  logic [NBYTES_W-1:0] count_q, count_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                zlp_q, zlp_d;
  logic                tog_q, tog_d;
  logic                halt_q, halt_d;
  logic                wr_en;
  logic                ack;
  logic [7:0]          mem_q [MAX_PKT];
  logic [7:0]          rd_q;

  assign o_ready     = (state_q == S_FILL);
  assign o_etValid   = (state_q != S_FILL);
  assign o_etStall   = halt_q;
  assign o_etDataPid = tog_q;
  assign o_etNBytes  = (state_q == S_SEALED) ? count_q : '0;
  assign o_etRdByte  = rd_q;

  // A halted endpoint answers with STALL, so an ACK can never be seen.
  assign ack = i_etReady && o_etValid && !halt_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idle_d  = idle_q;
    zlp_d   = zlp_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_FILL: begin
        if (i_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + NBYTES_W'(1);
          idle_d  = '0;
          if (count_d == NBYTES_W'(MAX_PKT) || i_last) begin
            state_d = S_SEALED;
            zlp_d   = i_last && (count_d == NBYTES_W'(MAX_PKT)) && (ZLP_EN != 0);
          end
        end else if (count_q != '0) begin
          if (idle_q == IDLE_W'(FLUSH_CYCLES)) begin
            state_d = S_SEALED;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      S_SEALED: begin
        if (ack) begin
          count_d = '0;
          state_d = zlp_q ? S_ZLP : S_FILL;
        end
      end
      S_ZLP: begin
        if (ack) begin
          zlp_d   = 1'b0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    tog_d = tog_q;
    if (i_toggleClr || i_haltClr) tog_d = 1'b0;
    else if (ack)                 tog_d = ~tog_q;
    halt_d = halt_q;
    if (i_haltSet)      halt_d = 1'b1;
    else if (i_haltClr) halt_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FILL;
      count_q <= '0;
      idle_q  <= '0;
      zlp_q   <= 1'b0;
      tog_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idle_q  <= idle_d;
      zlp_q   <= zlp_d;
      tog_q   <= tog_d;
      halt_q  <= halt_d;
    end
  end

  // Packet storage is deliberately not reset; count alone defines validity.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[count_q[IDX_W-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                          rd_q <= 8'h00;
    else if (int'(i_etRdIdx) < MAX_PKT) rd_q <= mem_q[i_etRdIdx];
    else                                rd_q <= 8'h00;
  end

endmodule

// File: tb/tb_usbfs_endp_in_buf.sv
// Bench for usbfs_endp_in_buf: instance A (MAX_PKT=8, FLUSH=0, ZLP on) and
// instance B (MAX_PKT=5, FLUSH=4, ZLP off). Bytes are pushed to exp_q as driven.
module tb_usbfs_endp_in_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_ready, a_valid, a_last, a_et_ready, a_et_valid, a_stall, a_pid;
  logic       a_tclr, a_hset, a_hclr;
  logic [7:0] a_data, a_rd;
  logic [3:0] a_nbytes;
  logic [2:0] a_idx;

  logic       b_ready, b_valid, b_last, b_et_ready, b_et_valid, b_stall, b_pid;
  logic       b_tclr, b_hset, b_hclr;
  logic [7:0] b_data, b_rd;
  logic [2:0] b_nbytes;
  logic [2:0] b_idx;

  usbfs_endp_in_buf #(.MAX_PKT(8), .FLUSH_CYCLES(0), .ZLP_EN(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .o_ready(a_ready), .i_valid(a_valid), .i_data(a_data),
    .i_last(a_last), .i_etReady(a_et_ready), .o_etValid(a_et_valid), .o_etStall(a_stall),
    .o_etDataPid(a_pid), .o_etNBytes(a_nbytes), .i_etRdIdx(a_idx), .o_etRdByte(a_rd),
    .i_toggleClr(a_tclr), .i_haltSet(a_hset), .i_haltClr(a_hclr)
  );

  usbfs_endp_in_buf #(.MAX_PKT(5), .FLUSH_CYCLES(4), .ZLP_EN(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .o_ready(b_ready), .i_valid(b_valid), .i_data(b_data),
    .i_last(b_last), .i_etReady(b_et_ready), .o_etValid(b_et_valid), .o_etStall(b_stall),
    .o_etDataPid(b_pid), .o_etNBytes(b_nbytes), .i_etRdIdx(b_idx), .o_etRdByte(b_rd),
    .i_toggleClr(b_tclr), .i_haltSet(b_hset), .i_haltClr(b_hclr)
  );

  typedef struct {
    int n;
    bit last;
    int exp_nbytes;
    bit exp_zlp;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         pid_a = 1'b0;
  bit         pid_b = 1'b0;
  int         cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b1;
      a_data  = 8'($urandom_range(0, 255));
      a_last  = last && (i == n - 1);
      exp_q.push_back(a_data);
      step();
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic send_b(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      b_valid = 1'b1;
      b_data  = 8'($urandom_range(0, 255));
      b_last  = last && (i == n - 1);
      exp_q.push_back(b_data);
      step();
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  task automatic wait_a(output int c);
    c = 0;
    while (!a_et_valid && c < 20) begin
      step();
      c++;
    end
    chk("a_seal_wait", int'(a_et_valid), 1);
  endtask

  task automatic wait_b(output int c);
    c = 0;
    while (!b_et_valid && c < 20) begin
      step();
      c++;
    end
    chk("b_seal_wait", int'(b_et_valid), 1);
  endtask

  task automatic read_a(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      a_idx = 3'(i);
      step();
      e = exp_q.pop_front();
      chk("a_rd_byte", int'(a_rd), int'(e));
    end
  endtask

  task automatic read_b(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      b_idx = 3'(i);
      step();
      e = exp_q.pop_front();
      chk("b_rd_byte", int'(b_rd), int'(e));
    end
  endtask

  task automatic ack_a();
    a_et_ready = 1'b1;
    step();
    a_et_ready = 1'b0;
    pid_a = ~pid_a;
  endtask

  task automatic ack_b();
    b_et_ready = 1'b1;
    step();
    b_et_ready = 1'b0;
    pid_b = ~pid_b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 8, last: 1'b0, exp_nbytes: 8, exp_zlp: 1'b0};
    vecs[1] = '{n: 8, last: 1'b1, exp_nbytes: 8, exp_zlp: 1'b1};
    vecs[2] = '{n: 3, last: 1'b1, exp_nbytes: 3, exp_zlp: 1'b0};
    vecs[3] = '{n: 3, last: 1'b0, exp_nbytes: 3, exp_zlp: 1'b0};
    vecs[4] = '{n: 1, last: 1'b0, exp_nbytes: 1, exp_zlp: 1'b0};
    vecs[5] = '{n: 7, last: 1'b1, exp_nbytes: 7, exp_zlp: 1'b0};

    // clock/reset
    rst = 1'b1;
    {a_valid, a_last, a_et_ready, a_tclr, a_hset, a_hclr} = '0;
    {b_valid, b_last, b_et_ready, b_tclr, b_hset, b_hclr} = '0;
    a_data = '0; b_data = '0; a_idx = '0; b_idx = '0;
    step();
    step();
    chk("rst_a_ready", int'(a_ready), 1);
    chk("rst_a_valid", int'(a_et_valid), 0);
    chk("rst_a_stall", int'(a_stall), 0);
    chk("rst_a_pid", int'(a_pid), 0);
    chk("rst_a_nbytes", int'(a_nbytes), 0);
    chk("rst_a_rdbyte", int'(a_rd), 0);
    chk("rst_b_ready", int'(b_ready), 1);
    chk("rst_b_valid", int'(b_et_valid), 0);
    rst = 1'b0;
    step();
    chk("idle_empty_no_seal", int'(a_et_valid), 0);

    // table-driven packets on A
    foreach (vecs[k]) begin
      send_a(vecs[k].n, vecs[k].last);
      wait_a(cyc);
      chk("vec_nbytes", int'(a_nbytes), vecs[k].exp_nbytes);
      chk("vec_pid", int'(a_pid), int'(pid_a));
      chk("vec_ready_low", int'(a_ready), 0);
      read_a(vecs[k].n);
      ack_a();
      if (vecs[k].exp_zlp) begin
        chk("zlp_valid", int'(a_et_valid), 1);
        chk("zlp_nbytes", int'(a_nbytes), 0);
        chk("zlp_pid", int'(a_pid), int'(pid_a));
        ack_a();
      end
      chk("post_ack_valid", int'(a_et_valid), 0);
      chk("post_ack_ready", int'(a_ready), 1);
      chk("post_ack_pid", int'(a_pid), int'(pid_a));
    end

    // retry: packet held across 50 unacknowledged cycles
    send_a(3, 1'b1);
    wait_a(cyc);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("retry_hold", int'({a_et_valid, a_ready, a_nbytes}), int'({1'b1, 1'b0, 4'd3}));
    end
    read_a(3);
    ack_a();
    chk("retry_ready", int'(a_ready), 1);

    // toggle clear wins over an ACK flip in the same cycle
    send_a(2, 1'b1);
    wait_a(cyc);
    read_a(2);
    a_et_ready = 1'b1;
    a_tclr = 1'b1;
    step();
    a_et_ready = 1'b0;
    a_tclr = 1'b0;
    pid_a = 1'b0;
    chk("tclr_pid", int'(a_pid), 0);
    chk("tclr_ready", int'(a_ready), 1);

    // halt during SEALED with PID=1
    send_a(1, 1'b1);
    wait_a(cyc);
    read_a(1);
    ack_a();
    send_a(2, 1'b1);
    wait_a(cyc);
    chk("halt_pre_pid", int'(a_pid), 1);
    a_hset = 1'b1;
    step();
    a_hset = 1'b0;
    chk("halt_stall", int'(a_stall), 1);
    for (int i = 0; i < 3; i++) begin
      a_et_ready = 1'b1;
      step();
      a_et_ready = 1'b0;
      step();
      chk("halt_ack_ignored", int'({a_et_valid, a_pid, a_nbytes}), int'({1'b1, 1'b1, 4'd2}));
    end
    a_hclr = 1'b1;
    step();
    a_hclr = 1'b0;
    pid_a = 1'b0;
    chk("hclr_stall", int'(a_stall), 0);
    chk("hclr_pid", int'(a_pid), 0);
    chk("hclr_offer", int'({a_et_valid, a_nbytes}), int'({1'b1, 4'd2}));
    read_a(2);
    a_hset = 1'b1;
    a_hclr = 1'b1;
    step();
    a_hset = 1'b0;
    a_hclr = 1'b0;
    chk("hboth_stall", int'(a_stall), 1);
    chk("hboth_pid", int'(a_pid), 0);
    a_hclr = 1'b1;
    step();
    a_hclr = 1'b0;
    ack_a();
    chk("halt_done_pid", int'(a_pid), int'(pid_a));
    chk("halt_done_ready", int'(a_ready), 1);

    // reset while SEALED with a ZLP pending
    send_a(8, 1'b1);
    wait_a(cyc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    pid_a = 1'b0;
    chk("mrst_outs", int'({a_ready, a_et_valid, a_stall, a_pid, a_nbytes}), int'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
    chk("mrst_rdbyte", int'(a_rd), 0);
    send_a(2, 1'b1);
    wait_a(cyc);
    chk("mrst_nbytes", int'(a_nbytes), 2);
    read_a(2);
    ack_a();
    chk("mrst_no_zlp", int'(a_et_valid), 0);
    chk("mrst_pid", int'(a_pid), int'(pid_a));

    // B: idle flush timing on a non-power-of-2 buffer
    send_b(2, 1'b0);
    wait_b(cyc);
    chk("b_flush_latency", cyc, 5);
    chk("b_flush_nbytes", int'(b_nbytes), 2);
    chk("b_pid0", int'(b_pid), int'(pid_b));
    read_b(2);
    b_idx = 3'd6;
    step();
    chk("b_oob_read", int'(b_rd), 0);
    ack_b();
    send_b(5, 1'b1);
    wait_b(cyc);
    chk("b_full_latency", cyc, 0);
    chk("b_full_nbytes", int'(b_nbytes), 5);
    read_b(5);
    ack_b();
    chk("b_no_zlp", int'(b_et_valid), 0);
    chk("b_ready", int'(b_ready), 1);
    chk("b_pid", int'(b_pid), int'(pid_b));
    send_b(5, 1'b0);
    wait_b(cyc);
    chk("b_full_nolast_latency", cyc, 0);
    chk("b_full_nolast_nbytes", int'(b_nbytes), 5);
    read_b(5);
    ack_b();
    chk("b_final_pid", int'(b_pid), int'(pid_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
